// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with ready handshake, memory timeout,
// sticky HALT/illegal-opcode traps. Define MC_RETIRE_COUNT_EN to build the retired-instruction counter.
module multicycle_controller #(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                mem_ready,
  output logic                InstrRead,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          ALUOp,
  output logic                Branch,
  output logic                Jump,
  output logic                JumpReg,
  output logic                Halt,
  output logic                IllegalOp,
  output logic                Timeout,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_HALT, C_ILLEGAL
  } class_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int TO_LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [WAIT_W-1:0] TO_LIM_W = TO_LIM[WAIT_W-1:0];

  state_t              r_state;
  state_t              w_next_state;
  class_t              r_class;
  class_t              w_class;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_halt;
  logic                r_illegal;
  logic                r_timeout;
  logic                w_in_wait;
  logic                w_wait_expire;

  always_comb begin
    case (Opcode)
      OPCODE_W'(7'b0110011): w_class = C_R;
      OPCODE_W'(7'b0010011): w_class = C_I;
      OPCODE_W'(7'b0000011): w_class = C_LOAD;
      OPCODE_W'(7'b0100011): w_class = C_STORE;
      OPCODE_W'(7'b1100011): w_class = C_BRANCH;
      OPCODE_W'(7'b1101111): w_class = C_JAL;
      OPCODE_W'(7'b1100111): w_class = C_JALR;
      OPCODE_W'(7'b0110111): w_class = C_LUI;
      OPCODE_W'(7'b1111111): w_class = C_HALT;
      default:               w_class = C_ILLEGAL;
    endcase
  end

  // The wait that would bring the count to the limit traps, unless mem_ready arrives in that cycle.
  assign w_in_wait     = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_wait_expire = (MEM_TIMEOUT > 0) && w_in_wait && !mem_ready && (r_wait_cnt == TO_LIM_W);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)          w_next_state = S_DECODE;
        else if (w_wait_expire) w_next_state = S_TRAP;
      end
      S_DECODE: begin
        if (w_class == C_HALT)         w_next_state = S_HALTED;
        else if (w_class == C_ILLEGAL) w_next_state = S_TRAP;
        else                           w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (r_class == C_BRANCH)                           w_next_state = S_FETCH;
        else if (r_class == C_LOAD || r_class == C_STORE)  w_next_state = S_MEM;
        else                                               w_next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)          w_next_state = (r_class == C_LOAD) ? S_WB : S_FETCH;
        else if (w_wait_expire) w_next_state = S_TRAP;
      end
      S_WB:    w_next_state = S_FETCH;
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_class    <= C_ILLEGAL;
      r_wait_cnt <= '0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_class <= w_class;
      if (r_state != w_next_state)   r_wait_cnt <= '0;
      else if (w_in_wait && !mem_ready) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      if (r_state == S_DECODE && w_class == C_HALT)    r_halt    <= 1'b1;
      if (r_state == S_DECODE && w_class == C_ILLEGAL) r_illegal <= 1'b1;
      if (w_wait_expire)                               r_timeout <= 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    InstrRead = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    ALUSrc    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = 2'b00;
    Branch    = 1'b0;
    Jump      = 1'b0;
    JumpReg   = 1'b0;
    Halt      = 1'b0;
    IllegalOp = 1'b0;
    Timeout   = 1'b0;
    state_o   = 3'd0;
    if (!reset) begin
      Halt      = r_halt;
      IllegalOp = r_illegal;
      Timeout   = r_timeout;
      state_o   = r_state;
      case (r_state)
        S_FETCH: begin
          InstrRead = 1'b1;
          IRWrite   = mem_ready;
        end
        S_EXEC: begin
          ALUSrc = r_class inside {C_I, C_LOAD, C_STORE, C_LUI, C_JALR};
          case (r_class)
            C_R, C_I: ALUOp = 2'b10;
            C_BRANCH: ALUOp = 2'b01;
            C_LUI:    ALUOp = 2'b11;
            default:  ALUOp = 2'b00;
          endcase
          if (r_class == C_BRANCH) begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_MEM: begin
          MemRead  = (r_class == C_LOAD);
          MemWrite = (r_class == C_STORE);
          PCWrite  = (r_class == C_STORE) && mem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          MemtoReg = (r_class == C_LOAD);
          Jump     = (r_class == C_JAL) || (r_class == C_JALR);
          JumpReg  = (r_class == C_JALR);
        end
        default: ;
      endcase
    end
  end

`ifdef MC_RETIRE_COUNT_EN
  logic [CNT_W-1:0] r_retired;

  always_ff @(posedge clk) begin
    if (reset)        r_retired <= '0;
    else if (PCWrite) r_retired <= r_retired + CNT_W'(1);
  end

  assign retired = reset ? '0 : r_retired;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction sequence model queues the expected
// outputs of every cycle; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;

  localparam int TO = 15;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
                         ST_WB = 3'd4, ST_HALTED = 3'd5, ST_TRAP = 3'd6;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5, K_JALR = 6,
                 K_LUI = 7, K_HALT = 8, K_ILL = 9;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_HALT = 7'b1111111;

  typedef struct packed {
    logic        instr_read, ir_write, pc_write, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0]  alu_op;
    logic        branch, jump, jump_reg, halt, illegal, timeout;
    logic [2:0]  state;
    logic [31:0] retired;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } exp_item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  Opcode = '0;
  logic        mem_ready = 1'b0;
  logic        InstrRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic        Branch, Jump, JumpReg, Halt, IllegalOp, Timeout;
  logic [2:0]  state_o;
  logic [31:0] retired;

  exp_item_t sb_q[$];
  exp_item_t mon_it;
  obs_t      mon_act;
  int        checks = 0;
  int        failures = 0;

  logic        m_halt = 1'b0, m_ill = 1'b0, m_to = 1'b0;
  logic [31:0] m_retired = '0;
  logic [2:0]  m_state = ST_FETCH;
  logic [6:0]  legal_ops [8] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI};

  multicycle_controller #(.OPCODE_W(7), .MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .InstrRead(InstrRead), .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUOp(ALUOp), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .Halt(Halt),
    .IllegalOp(IllegalOp), .Timeout(Timeout), .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_it  = sb_q.pop_front();
        mon_act = {InstrRead, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                   ALUOp, Branch, Jump, JumpReg, Halt, IllegalOp, Timeout, state_o, retired};
        checks++;
        if (mon_act !== mon_it.v) begin
          failures++;
          $display("FAIL %s @%0t: got %h required %h", mon_it.tag, $time, mon_act, mon_it.v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int kind(input logic [6:0] op);
    case (op)
      OP_R:     return K_R;
      OP_I:     return K_I;
      OP_LOAD:  return K_LOAD;
      OP_STORE: return K_STORE;
      OP_BR:    return K_BR;
      OP_JAL:   return K_JAL;
      OP_JALR:  return K_JALR;
      OP_LUI:   return K_LUI;
      OP_HALT:  return K_HALT;
      default:  return K_ILL;
    endcase
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t e = '0;
    e.state   = st;
    e.halt    = m_halt;
    e.illegal = m_ill;
    e.timeout = m_to;
`ifdef MC_RETIRE_COUNT_EN
    e.retired = m_retired;
`endif
    return e;
  endfunction

  task automatic cyc(input logic [6:0] op, input logic rdy, input obs_t e, input string tag);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    Opcode    = op;
    mem_ready = rdy;
    sb_q.push_back('{e, tag});
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset     = 1'b1;
      Opcode    = 7'($urandom);
      mem_ready = 1'($urandom);
      sb_q.push_back('{obs_t'('0), "reset"});
    end
    m_halt    = 1'b0;
    m_ill     = 1'b0;
    m_to      = 1'b0;
    m_retired = '0;
    m_state   = ST_FETCH;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(7'($urandom), 1'($urandom), base(m_state), "absorb");
  endtask

  // fw/mw: wait cycles before mem_ready in FETCH/MEM; abort_at >= 0 stops inside MEM for a reset.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int abort_at);
    int   k = kind(op);
    obs_t e;
    logic rdy;
    for (int i = 0; i <= fw; i++) begin
      rdy = (i == fw);
      e = base(ST_FETCH);
      e.instr_read = 1'b1;
      e.ir_write   = rdy;
      cyc(7'($urandom), rdy, e, "fetch");
      if (!rdy && i == TO - 1) begin
        m_to = 1'b1; m_state = ST_TRAP;
        return;
      end
    end
    cyc(op, 1'($urandom), base(ST_DECODE), "decode");
    if (k == K_HALT) begin
      m_halt = 1'b1; m_state = ST_HALTED;
      return;
    end
    if (k == K_ILL) begin
      m_ill = 1'b1; m_state = ST_TRAP;
      return;
    end
    e = base(ST_EXEC);
    e.alu_src = k inside {K_I, K_LOAD, K_STORE, K_LUI, K_JALR};
    e.alu_op  = (k == K_R || k == K_I) ? 2'b10 : (k == K_BR) ? 2'b01 : (k == K_LUI) ? 2'b11 : 2'b00;
    if (k == K_BR) begin
      e.branch   = 1'b1;
      e.pc_write = 1'b1;
      cyc(op, 1'($urandom), e, "exec_branch");
      m_retired++;
      return;
    end
    cyc(op, 1'($urandom), e, "exec");
    if (k == K_LOAD || k == K_STORE) begin
      for (int j = 0; j <= mw; j++) begin
        if (j == abort_at) return;
        rdy = (j == mw);
        e = base(ST_MEM);
        e.mem_read  = (k == K_LOAD);
        e.mem_write = (k == K_STORE);
        e.pc_write  = (k == K_STORE) && rdy;
        cyc(op, rdy, e, "mem");
        if (k == K_STORE && rdy) begin
          m_retired++;
          return;
        end
        if (!rdy && j == TO - 1) begin
          m_to = 1'b1; m_state = ST_TRAP;
          return;
        end
      end
    end
    e = base(ST_WB);
    e.reg_write  = 1'b1;
    e.pc_write   = 1'b1;
    e.mem_to_reg = (k == K_LOAD);
    e.jump       = (k == K_JAL) || (k == K_JALR);
    e.jump_reg   = (k == K_JALR);
    cyc(op, 1'($urandom), e, "wb");
    m_retired++;
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    do_reset(2);
    run_instr(OP_R, 0, 0, -1);
    run_instr(OP_LOAD, 0, 3, -1);
    run_instr(OP_BR, 0, 0, -1);
    run_instr(OP_R, 14, 0, -1);
    run_instr(OP_STORE, 2, 14, -1);
    run_instr(OP_LOAD, 1, 14, -1);

    repeat (40) run_instr(legal_ops[$urandom_range(0, 7)], rand_wait(), rand_wait(), -1);

    run_instr(OP_HALT, 1, 0, -1);
    idle(20);
    do_reset(1);
    run_instr(OP_I, 0, 0, -1);

    run_instr(OP_R, 100, 0, -1);
    idle(3);
    do_reset(1);
    run_instr(OP_STORE, 0, 100, -1);
    idle(2);
    do_reset(1);
    run_instr(7'b0000000, 0, 0, -1);
    idle(3);
    do_reset(1);

    repeat (10) begin
      run_instr(7'($urandom), rand_wait(), rand_wait(), -1);
      if (m_state != ST_FETCH) begin
        idle(2);
        do_reset(1);
      end
    end

    run_instr(OP_STORE, 0, 100, 2);
    do_reset(1);
    run_instr(OP_JAL, 0, 0, -1);
    run_instr(OP_JALR, 1, 0, -1);
    run_instr(OP_LUI, 0, 0, -1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
